// File: rtl/apb_pkg.sv
// Shared state encoding and width helpers for the APB requester bridge and its decoder.
// Declarations only: no logic, no latency, no flow control.
package apb_pkg;

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_setup  = 2'd1,
    st_access = 2'd2,
    st_decerr = 2'd3
  } apb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough to hold the value 'limit' itself; a disabled timeout still needs one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps a byte address onto N equal power-of-two regions: in_range flag, region index, one-hot select.
// Purely combinational, zero latency, no flow control.
module apb_addr_decoder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    NUM_SLAVES    = 4,
  parameter int                    SLV_ADDR_BITS = 5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    IDX_W         = 2
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  in_range,
  output logic [IDX_W-1:0]      idx,
  output logic [NUM_SLAVES-1:0] sel
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] region;

  // Below BASE_ADDR the subtraction wraps, so the lower bound is tested on the raw address.
  assign offset   = addr - BASE_ADDR;
  assign region   = offset >> SLV_ADDR_BITS;
  assign in_range = (addr >= BASE_ADDR) && (region < ADDR_WIDTH'(NUM_SLAVES));
  assign idx      = region[IDX_W-1:0];

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = in_range && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/apb_master_bridge_n.sv
// APB4 requester: one MREQ/MREADY master port fanned out to NUM_SLAVES completers with decode-error and PREADY-timeout aborts.
// MREADY 3 cycles after MREQ is sampled (+1 per wait state, 2 on decode error); requests are taken only in IDLE, PREADY stalls ACCESS.
module apb_master_bridge_n
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    STROBE_WIDTH  = DATA_WIDTH / 8,
  parameter int                    PROT_WIDTH    = 3,
  parameter int                    NUM_SLAVES    = 4,
  parameter int                    SLV_ADDR_BITS = 5,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    TIMEOUT       = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [ADDR_WIDTH-1:0]            MADDR,
  input  logic [DATA_WIDTH-1:0]            MWDATA,
  input  logic [STROBE_WIDTH-1:0]          MSTRB,
  input  logic                             MWRITE,
  input  logic                             MREQ,
  input  logic [PROT_WIDTH-1:0]            MPROT,
  output logic                             MSLVERR,
  output logic [DATA_WIDTH-1:0]            MRDATA,
  output logic                             MREADY,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STROBE_WIDTH-1:0]          PSTRB,
  output logic [PROT_WIDTH-1:0]            PPROT,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int IDX_W = idx_width(NUM_SLAVES);
  localparam int TO_W  = cnt_width(TIMEOUT);

  apb_state_t state, state_nxt;

  logic                  dec_in_range;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_SLAVES-1:0] dec_sel;

  logic [IDX_W-1:0]      idx_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [TO_W-1:0]       to_cnt;

  logic [DATA_WIDTH-1:0] prdata_sel;
  logic                  pready_sel;
  logic                  pslverr_sel;
  logic                  req_take;
  logic                  timed_out;

  apb_addr_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .NUM_SLAVES   (NUM_SLAVES),
    .SLV_ADDR_BITS(SLV_ADDR_BITS),
    .BASE_ADDR    (BASE_ADDR),
    .IDX_W        (IDX_W)
  ) u_dec (
    .addr    (MADDR),
    .in_range(dec_in_range),
    .idx     (dec_idx),
    .sel     (dec_sel)
  );

  assign req_take  = (state == st_idle) && MREQ;
  assign timed_out = (TIMEOUT != 0) && (state == st_access) && !pready_sel &&
                     (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    prdata_sel  = '0;
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        prdata_sel  = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
        pready_sel  = PREADY[i];
        pslverr_sel = PSLVERR[i];
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= st_idle;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      st_idle:   if (MREQ) state_nxt = dec_in_range ? st_setup : st_decerr;
      st_setup:  state_nxt = st_access;
      st_access: if (pready_sel || timed_out) state_nxt = st_idle;
      st_decerr: state_nxt = st_idle;
      default:   state_nxt = st_idle;
    endcase
  end

  always_comb begin
    PSEL    = '0;
    PENABLE = 1'b0;
    if (state == st_setup || state == st_access) PSEL = sel_q;
    if (state == st_access) PENABLE = 1'b1;
  end

  // Bus fields come straight from this latch, so they cannot move between SETUP and ACCESS.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PSTRB  <= '0;
      PWRITE <= 1'b0;
      PPROT  <= '0;
      idx_q  <= '0;
      sel_q  <= '0;
    end else if (req_take) begin
      PADDR  <= MADDR;
      PWDATA <= MWDATA;
      PSTRB  <= MWRITE ? MSTRB : '0;
      PWRITE <= MWRITE;
      PPROT  <= MPROT;
      idx_q  <= dec_idx;
      sel_q  <= dec_sel;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      to_cnt <= '0;
    end else if (req_take && dec_in_range) begin
      to_cnt <= '0;
    end else if (state == st_access && !pready_sel) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      MREADY  <= 1'b0;
      MSLVERR <= 1'b0;
      MRDATA  <= '0;
    end else begin
      MREADY <= 1'b0;
      if (state == st_access && pready_sel) begin
        MREADY  <= 1'b1;
        MSLVERR <= pslverr_sel;
        MRDATA  <= PWRITE ? '0 : prdata_sel;
      end else if (timed_out || state == st_decerr) begin
        MREADY  <= 1'b1;
        MSLVERR <= 1'b1;
        MRDATA  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge_n.sv
// Bench for apb_master_bridge_n: directed vector table, timeout and reset sequences, then random traffic vs a byte-array model.
module tb_apb_master_bridge_n;

  localparam int NS   = 4;
  localparam int TMO  = 16;
  localparam int HANG = 255;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic [31:0]      MADDR;
  logic [31:0]      MWDATA;
  logic [3:0]       MSTRB;
  logic             MWRITE;
  logic             MREQ;
  logic [2:0]       MPROT;
  logic             MSLVERR;
  logic [31:0]      MRDATA;
  logic             MREADY;
  logic [31:0]      PADDR;
  logic [NS-1:0]    PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [31:0]      PWDATA;
  logic [3:0]       PSTRB;
  logic [2:0]       PPROT;
  logic [NS*32-1:0] PRDATA;
  logic [NS-1:0]    PREADY;
  logic [NS-1:0]    PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_master_bridge_n #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_WIDTH(3), .NUM_SLAVES(NS),
    .SLV_ADDR_BITS(5), .BASE_ADDR(32'h0), .TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .MADDR(MADDR), .MWDATA(MWDATA), .MSTRB(MSTRB),
    .MWRITE(MWRITE), .MREQ(MREQ), .MPROT(MPROT), .MSLVERR(MSLVERR), .MRDATA(MRDATA),
    .MREADY(MREADY), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  // Completer array: 32-byte memory per slave, configurable wait states and error response.
  int         wait_cfg [NS];
  logic       err_cfg  [NS];
  int         acc_cnt;
  logic [7:0] smem [NS][32];

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      int wb;
      wb = int'({PADDR[4:2], 2'b00});
      PREADY[i]  = PSEL[i] && PENABLE && (wait_cfg[i] != HANG) && (acc_cnt >= wait_cfg[i]);
      PSLVERR[i] = err_cfg[i];
      PRDATA[i*32 +: 32] = {smem[i][wb+3], smem[i][wb+2], smem[i][wb+1], smem[i][wb]};
    end
  end

  always @(posedge PCLK) begin
    if (!PRESETn) begin
      acc_cnt <= 0;
      for (int i = 0; i < NS; i++)
        for (int b = 0; b < 32; b++) smem[i][b] <= 8'h00;
    end else begin
      if (PENABLE && (|PSEL) && !(|PREADY)) acc_cnt <= acc_cnt + 1;
      else                                  acc_cnt <= 0;
      for (int i = 0; i < NS; i++) begin
        if (PSEL[i] && PENABLE && PREADY[i] && PWRITE) begin
          for (int b = 0; b < 4; b++)
            if (PSTRB[b]) smem[i][int'({PADDR[4:2], 2'b00}) + b] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  // Reference model: what each slave's bytes should hold after the completed writes.
  logic [7:0] ref_mem [NS][32];

  function automatic logic [31:0] ref_word(input int s, input int a);
    int wb;
    wb = a & 'h1C;
    return {ref_mem[s][wb+3], ref_mem[s][wb+2], ref_mem[s][wb+1], ref_mem[s][wb]};
  endfunction

  task automatic ref_apply(input int s, input int a, input logic [31:0] d, input logic [3:0] st);
    int wb;
    wb = a & 'h1C;
    for (int b = 0; b < 4; b++)
      if (st[b]) ref_mem[s][wb+b] = d[8*b +: 8];
  endtask

  task automatic ref_clear();
    for (int i = 0; i < NS; i++)
      for (int b = 0; b < 32; b++) ref_mem[i][b] = 8'h00;
  endtask

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (#%0d): got 0x%0h, expected 0x%0h", nm, id, act, exp);
    end
  endtask

  task automatic set_slaves(input int w, input logic e);
    for (int i = 0; i < NS; i++) begin
      wait_cfg[i] = w;
      err_cfg[i]  = e;
    end
  endtask

  // Called at a negedge while the bridge is IDLE (or in its MREADY cycle); returns at the MREADY-cycle negedge.
  task automatic xfer(input int id, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot, input logic hold,
                      input logic [3:0] exp_sel, input int exp_lat, input logic exp_err,
                      input logic [31:0] exp_rdata, input logic [3:0] exp_pstrb);
    int   lat;
    logic bad_sel, bad_en, bad_bus;
    MADDR = addr; MWRITE = wr; MWDATA = wdata; MSTRB = strb; MPROT = prot; MREQ = 1'b1;
    @(posedge PCLK);
    if (!hold) begin
      #1 MREQ = 1'b0;
    end
    lat = 0; bad_sel = 1'b0; bad_en = 1'b0; bad_bus = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge PCLK);
      if (MREADY) begin
        lat = n;
        break;
      end
      if (PSEL !== exp_sel) bad_sel = 1'b1;
      if (PENABLE !== (n >= 2)) bad_en = 1'b1;
      if (exp_sel != '0 && (PADDR !== addr || PWRITE !== wr || PWDATA !== wdata ||
                            PSTRB !== exp_pstrb || PPROT !== prot)) bad_bus = 1'b1;
    end
    chk("latency", id, 64'(lat), 64'(exp_lat));
    chk("psel", id, 64'(bad_sel), 64'(0));
    chk("penable", id, 64'(bad_en), 64'(0));
    if (exp_sel != '0) chk("pbus_fields", id, 64'(bad_bus), 64'(0));
    chk("mslverr", id, 64'(MSLVERR), 64'(exp_err));
    chk("mrdata", id, 64'(MRDATA), 64'(exp_rdata));
    chk("bus_idle_at_mready", id, 64'({PSEL, PENABLE}), 64'(0));
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        serr;
    logic        hold;
    int          idle_before;
    logic [3:0]  exp_sel;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_pstrb;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{32'h1F, 1'b1, 32'h0000_0055, 4'hF, 3'd0, 0, 1'b0, 1'b1, 0, 4'b0001, 3, 1'b0, 32'h0, 4'hF};
    vt[1] = '{32'h3F, 1'b1, 32'h8800_0055, 4'h8, 3'd1, 0, 1'b0, 1'b0, 0, 4'b0010, 3, 1'b0, 32'h0, 4'h8};
    vt[2] = '{32'h1F, 1'b0, 32'h0000_0000, 4'hF, 3'd0, 2, 1'b0, 1'b0, 3, 4'b0001, 5, 1'b0, 32'h0000_0055, 4'h0};
    vt[3] = '{32'h80, 1'b0, 32'h0000_0000, 4'h0, 3'd0, 0, 1'b0, 1'b0, 1, 4'b0000, 2, 1'b1, 32'h0, 4'h0};
    vt[4] = '{32'h60, 1'b1, 32'h1234_5678, 4'hF, 3'd5, 0, 1'b1, 1'b0, 1, 4'b1000, 3, 1'b1, 32'h0, 4'hF};
    vt[5] = '{32'h3C, 1'b0, 32'hDEAD_BEEF, 4'h3, 3'd2, 1, 1'b0, 1'b1, 0, 4'b0010, 4, 1'b0, 32'h8800_0000, 4'h0};
    vt[6] = '{32'h60, 1'b0, 32'h0000_0000, 4'h0, 3'd7, 0, 1'b1, 1'b0, 0, 4'b1000, 3, 1'b1, 32'h1234_5678, 4'h0};

    ref_clear();
    set_slaves(0, 1'b0);
    PRESETn = 1'b0; MREQ = 1'b0; MADDR = '0; MWDATA = '0; MSTRB = '0; MWRITE = 1'b0; MPROT = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_psel_penable", 0, 64'({PSEL, PENABLE}), 64'(0));
    chk("reset_mready_mslverr", 0, 64'({MREADY, MSLVERR}), 64'(0));
    chk("reset_mrdata", 0, 64'(MRDATA), 64'(0));
    chk("reset_pbus", 0, 64'({PADDR, PWRITE, PSTRB, PPROT}), 64'(0));
    PRESETn = 1'b1;
    @(negedge PCLK);

    for (int i = 0; i < 7; i++) begin
      set_slaves(vt[i].waits, vt[i].serr);
      if (vt[i].idle_before > 0) begin
        MREQ = 1'b0;
        repeat (vt[i].idle_before) @(negedge PCLK);
      end
      xfer(i, vt[i].addr, vt[i].wr, vt[i].wdata, vt[i].strb, vt[i].prot, vt[i].hold,
           vt[i].exp_sel, vt[i].exp_lat, vt[i].exp_err, vt[i].exp_rdata, vt[i].exp_pstrb);
      if (vt[i].wr && vt[i].exp_sel != '0)
        ref_apply(int'(vt[i].addr >> 5), int'(vt[i].addr & 32'h1F), vt[i].wdata, vt[i].strb);
    end
    MREQ = 1'b0;
    @(negedge PCLK);

    // Hung slave 2 is aborted after TMO access cycles; slave 1 then completes normally.
    set_slaves(0, 1'b0);
    wait_cfg[2] = HANG;
    xfer(200, 32'h40, 1'b0, 32'h0, 4'hF, 3'd0, 1'b0, 4'b0100, 2 + TMO, 1'b1, 32'h0, 4'h0);
    wait_cfg[2] = 0;
    xfer(201, 32'h24, 1'b0, 32'h0, 4'h0, 3'd0, 1'b0, 4'b0010, 3, 1'b0, ref_word(1, 4), 4'h0);
    @(negedge PCLK);

    // Reset while stuck in ACCESS: bus drops on the next edge and no completion is reported.
    wait_cfg[1] = HANG;
    MADDR = 32'h20; MWRITE = 1'b1; MWDATA = 32'hCAFE_F00D; MSTRB = 4'hF; MPROT = 3'd0; MREQ = 1'b1;
    @(posedge PCLK);
    #1 MREQ = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("pre_reset_in_access", 300, 64'({PSEL, PENABLE}), 64'({4'b0010, 1'b1}));
    PRESETn = 1'b0;
    @(negedge PCLK);
    chk("midreset_psel_penable", 300, 64'({PSEL, PENABLE}), 64'(0));
    chk("midreset_mready", 300, 64'(MREADY), 64'(0));
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("postreset_mready", 300, 64'(MREADY), 64'(0));
    wait_cfg[1] = 0;
    ref_clear();

    for (int r = 0; r < 80; r++) begin
      logic [31:0] addr, wdata;
      logic        wr, e, hold, inr;
      logic [3:0]  strb, esel;
      logic [2:0]  prot;
      int          w, gap, s;
      addr  = 32'($urandom_range(0, 159));
      wr    = 1'($urandom_range(0, 1));
      wdata = $urandom;
      strb  = 4'($urandom_range(0, 15));
      prot  = 3'($urandom_range(0, 7));
      w     = $urandom_range(0, 3);
      e     = 1'($urandom_range(0, 1));
      hold  = 1'($urandom_range(0, 1));
      gap   = $urandom_range(0, 2);
      set_slaves(w, e);
      inr  = (addr < 32'(NS * 32));
      s    = int'(addr) / 32;
      esel = inr ? 4'(1 << s) : 4'b0000;
      xfer(100 + r, addr, wr, wdata, strb, prot, hold, esel,
           inr ? 3 + w : 2,
           inr ? e : 1'b1,
           (inr && !wr) ? ref_word(s, int'(addr) % 32) : 32'h0,
           wr ? strb : 4'h0);
      if (inr && wr) ref_apply(s, int'(addr) % 32, wdata, strb);
      if (!hold) begin
        MREQ = 1'b0;
        repeat (gap) @(negedge PCLK);
      end
    end
    MREQ = 1'b0;
    repeat (2) @(negedge PCLK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
